// File: rtl/mau_host_ctrl.sv
// MAU host controller: issues one MAU instruction and streams a matrix into or out of the MAU.
// Optional MAU_HOST_TIMEOUT_EN adds a 10-bit watchdog on the streaming and completion states.
module mau_host_ctrl #(
  parameter int matrix_dim = 8,
  parameter int BUSY_WAIT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_instr,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] ld_data,
  input  logic       ld_valid,
  output logic       ld_ready,
  output logic [7:0] ul_data,
  output logic       ul_valid,
  output logic [7:0] host_instruction,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  input  logic       busy_flag,
  output logic       done,
  output logic [1:0] err
);

  localparam logic [6:0]        LAST_BYTE = 7'(matrix_dim * matrix_dim - 1);
  localparam int unsigned       WAIT_W    = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, STREAM_LD, STREAM_UL, WAIT_DONE
  } state_t;

  typedef enum logic [1:0] {K_LOAD, K_UNLOAD, K_OTHER} kind_t;

  state_t            r_state;
  kind_t             r_kind;
  kind_t             w_kind;
  logic [6:0]        r_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic [7:0]        r_host;
  logic [7:0]        r_data_in;
  logic              r_done;
  logic [1:0]        r_err;
  logic              r_cmd_ready;
  logic              w_last;
`ifdef MAU_HOST_TIMEOUT_EN
  logic [9:0]        r_wdog;
`endif

  always_comb begin
    w_kind = K_OTHER;
    if (cmd_instr[3:2] == 2'b01 && cmd_instr[1:0] == 2'b00)
      w_kind = K_LOAD;
    else if (cmd_instr[3:2] == 2'b01 && cmd_instr[1:0] == 2'b10)
      w_kind = K_UNLOAD;
  end

  assign w_last = (r_cnt == LAST_BYTE);

  // Stream handshakes are combinational: the MAU cannot be stalled, so they track the live inputs.
  assign ld_ready         = (r_state == STREAM_LD) && ld_valid;
  assign ul_valid         = (r_state == STREAM_UL) && busy_flag;
  assign ul_data          = ul_valid ? data_out : '0;
  assign cmd_ready        = r_cmd_ready;
  assign host_instruction = r_host;
  assign data_in          = r_data_in;
  assign done             = r_done;
  assign err              = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_kind      <= K_OTHER;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_host      <= '0;
      r_data_in   <= '0;
      r_done      <= 1'b0;
      r_err       <= '0;
      r_cmd_ready <= 1'b0;
`ifdef MAU_HOST_TIMEOUT_EN
      r_wdog      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          r_host      <= '0;
          if (cmd_valid && r_cmd_ready) begin
            r_err <= '0;
            if (cmd_instr == 8'h00) begin
              r_done <= 1'b1;
            end else begin
              r_host      <= cmd_instr;
              r_kind      <= w_kind;
              r_cnt       <= '0;
              r_wait      <= '0;
              r_cmd_ready <= 1'b0;
              r_state     <= ISSUE;
`ifdef MAU_HOST_TIMEOUT_EN
              r_wdog      <= '0;
`endif
            end
          end
        end
        ISSUE: begin
          r_host  <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy_flag) begin
            case (r_kind)
              K_LOAD:   r_state <= STREAM_LD;
              K_UNLOAD: r_state <= STREAM_UL;
              default:  r_state <= WAIT_DONE;
            endcase
          end else if (r_wait == WAIT_LAST) begin
            r_err[1]    <= 1'b1;
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        STREAM_LD: begin
          if (ld_valid) r_data_in <= ld_data;
          else          r_err[0]  <= 1'b1;
          if (w_last || !busy_flag) r_state <= WAIT_DONE;
          else                      r_cnt   <= r_cnt + 7'd1;
        end
        STREAM_UL: begin
          if (w_last || !busy_flag) r_state <= WAIT_DONE;
          else                      r_cnt   <= r_cnt + 7'd1;
        end
        WAIT_DONE: begin
          if (!busy_flag) begin
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
`ifdef MAU_HOST_TIMEOUT_EN
      // Placed after the case so an expiring watchdog overrides any state transition above.
      if (r_state == STREAM_LD || r_state == STREAM_UL || r_state == WAIT_DONE) begin
        if (r_wdog == '1) begin
          r_err[1]    <= 1'b1;
          r_done      <= 1'b1;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end else begin
          r_wdog <= r_wdog + 10'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mau_host_ctrl.sv
// Scoreboard bench for mau_host_ctrl: directed commands push expectations, a negedge monitor pops and compares.
module tb_mau_host_ctrl;

  localparam int BW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd_instr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ul_data;
  logic       ul_valid;
  logic [7:0] host_instruction;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy_flag;
  logic       done;
  logic [1:0] err;

  mau_host_ctrl #(.matrix_dim(8), .BUSY_WAIT(BW)) dut (
    .clk(clk), .rst(rst), .cmd_instr(cmd_instr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready), .ul_data(ul_data), .ul_valid(ul_valid),
    .host_instruction(host_instruction), .data_in(data_in), .data_out(data_out),
    .busy_flag(busy_flag), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       chk;
    logic [7:0] din;
  } ld_exp_t;

  ld_exp_t    q_ld[$];
  logic [7:0] q_host[$];
  logic [7:0] q_ul[$];
  logic [1:0] q_done[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int done_cyc = 0;
  ld_exp_t m_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (host_instruction != 8'h00) begin
        if (q_host.size() == 0) flag("host_extra", host_instruction, 0);
        else check("host_instr", host_instruction, q_host.pop_front());
      end
      if (q_ld.size() != 0) begin
        m_e = q_ld.pop_front();
        check("ld_ready", ld_ready, m_e.rdy);
        if (m_e.chk) check("data_in", data_in, m_e.din);
      end else if (ld_ready) begin
        flag("ld_ready_extra", ld_ready, 0);
      end
      if (ul_valid) begin
        if (q_ul.size() == 0) flag("ul_valid_extra", ul_data, 0);
        else check("ul_data", ul_data, q_ul.pop_front());
      end
      if (done) begin
        done_cyc = cyc;
        if (q_done.size() == 0) flag("done_extra", err, 0);
        else check("err_at_done", err, q_done.pop_front());
      end
    end
  end

  task automatic issue(input logic [7:0] c);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_instr = c;
    cmd_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag("cmd_accept_timeout", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    accept_cyc = cyc;
    if (ok && c != 8'h00) q_host.push_back(c);
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (q_done.size() == 0) break;
    end
    if (q_done.size() != 0) begin
      flag(name, q_done.size(), 0);
      q_done.delete();
    end
  endtask

  task automatic run_load(input int gap_lo, input int gap_hi, input int abort_after);
    logic [7:0] last;
    logic       v;
    last     = 8'h00;
    ld_valid = 1'b1;
    ld_data  = 8'd1;
    issue(8'b10_00_01_00);
    if (abort_after == 0) q_done.push_back((gap_hi >= gap_lo) ? 2'b01 : 2'b00);
    @(posedge clk); #1;
    busy_flag = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (abort_after != 0 && i > abort_after) break;
      v = !(i >= gap_lo && i <= gap_hi);
      ld_valid = v;
      ld_data  = v ? 8'(i) : 8'hEE;
      q_ld.push_back('{rdy: v, chk: (i > 1), din: last});
      if (v) last = 8'(i);
    end
    if (abort_after != 0) begin
      rst       = 1'b1;
      busy_flag = 1'b0;
      ld_valid  = 1'b1;
      data_out  = 8'h5A;
      @(posedge clk); #1;
      check("abort_host", host_instruction, 8'h00);
      check("abort_data_in", data_in, 8'h00);
      check("abort_ul_data", ul_data, 8'h00);
      check("abort_ul_valid", ul_valid, 0);
      check("abort_ld_ready", ld_ready, 0);
      check("abort_done", done, 0);
      check("abort_err", err, 0);
      check("abort_cmd_ready", cmd_ready, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_cmd_ready_after", cmd_ready, 1);
      check("abort_no_done", done, 0);
      repeat (3) @(posedge clk);
      #1;
    end else begin
      @(posedge clk); #1;
      busy_flag = 1'b0;
      ld_valid  = 1'b1;
      q_ld.push_back('{rdy: 1'b0, chk: 1'b1, din: last});
      wait_done("load_done_timeout");
    end
  endtask

  task automatic run_unload();
    issue(8'b01_00_01_10);
    q_done.push_back(2'b00);
    for (int i = 1; i <= 64; i++) q_ul.push_back(8'(i));
    @(posedge clk); #1;
    busy_flag = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      data_out = 8'(i);
    end
    @(posedge clk); #1;
    busy_flag = 1'b0;
    data_out  = 8'hAA;
    wait_done("unload_done_timeout");
    check("ul_count_left", q_ul.size(), 0);
    q_ul.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    cmd_instr = 8'h00;
    cmd_valid = 1'b0;
    ld_data   = 8'h33;
    ld_valid  = 1'b1;
    data_out  = 8'h55;
    busy_flag = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_host", host_instruction, 8'h00);
    check("rst_data_in", data_in, 8'h00);
    check("rst_ul_data", ul_data, 8'h00);
    check("rst_ul_valid", ul_valid, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    rst       = 1'b0;
    busy_flag = 1'b0;
    @(posedge clk); #1;
    check("cmd_ready_after_rst", cmd_ready, 1);

    run_load(0, -1, 0);
    run_unload();
    run_load(10, 12, 0);
    @(posedge clk); #1;
    check("err_sticky", err, 2'b01);

    ld_valid = 1'b1;
    issue(8'b00_01_11_00);
    q_done.push_back(2'b00);
    @(posedge clk); #1;
    busy_flag = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    busy_flag = 1'b0;
    wait_done("add_done_timeout");

    issue(8'b01_00_10_00);
    q_done.push_back(2'b10);
    wait_done("busy_timeout_done_timeout");
    check("busy_timeout_latency", done_cyc - accept_cyc, BW + 1);

    issue(8'h00);
    q_done.push_back(2'b00);
    wait_done("nop_done_timeout");
    check("nop_latency", done_cyc - accept_cyc, 0);

    run_load(0, -1, 30);

    check("host_queue_left", q_host.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mau_host_ctrl.md
MAU_HOST_CTRL -- requirements
Module: mau_host_ctrl

Interface
REQ-001 SHALL have parameter matrix_dim, default 8: matrix side length; one transfer is matrix_dim*matrix_dim bytes (64 at default).
REQ-002 SHALL have parameter BUSY_WAIT, default 2: maximum cycles allowed after issue for busy_flag to rise.
REQ-003 SHALL have one clock and synchronous active-high reset, both as in the codebase.
REQ-004 Ports, name direction width meaning:
  clk  in  1  clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  cmd_instr  in  8  MAU instruction: [7:6] dest, [5:4] src, [3:2] class, [1:0] op
  cmd_valid  in  1  command request
  cmd_ready  out  1  controller idle; command accepted when cmd_valid & cmd_ready
  ld_data  in  8  load byte
  ld_valid  in  1  load byte available
  ld_ready  out  1  load byte consumed this cycle
  ul_data  out  8  unloaded byte
  ul_valid  out  1  ul_data valid, no backpressure
  host_instruction  out  8  to MAU
  data_in  out  8  to MAU
  data_out  in  8  from MAU
  busy_flag  in  1  MAU busy
  done  out  1  one-cycle pulse at command completion
  err  out  2  sticky: [0] load underrun, [1] busy timeout

Function
REQ-005 Command classes: class 01 op 00 = LOAD, class 01 op 10 = UNLOAD; every other non-zero instruction is OTHER (COPY, CLEAR, ADD); 8'h00 is NOP.
REQ-006 States: IDLE, ISSUE, WAIT_BUSY, STREAM_LD, STREAM_UL, WAIT_DONE.
REQ-007 IDLE: cmd_ready=1 and host_instruction=8'h00; on accept, SHALL latch cmd_instr and go to ISSUE. A NOP command SHALL complete with done in the next cycle and no issue.
REQ-008 ISSUE: host_instruction SHALL equal the latched instruction for exactly one cycle, then return to 8'h00; next state WAIT_BUSY.
REQ-009 WAIT_BUSY: on busy_flag=1, go to STREAM_LD (LOAD), STREAM_UL (UNLOAD) or WAIT_DONE (OTHER). If busy_flag is not seen within BUSY_WAIT cycles, SHALL set err[1], pulse done and go to IDLE.
REQ-010 The 7-bit byte counter SHALL clear on issue. It SHALL increment once per byte transferred and terminate at matrix_dim*matrix_dim-1 without wrapping.
REQ-011 STREAM_LD: each cycle, data_in<=ld_data and ld_ready=1 when ld_valid=1. If ld_valid=0, data_in SHALL hold its last value, err[0] SHALL set, and the counter SHALL still advance, because the MAU cannot be stalled.
REQ-012 STREAM_UL: each cycle with busy_flag=1 and the count not exhausted, ul_data SHALL equal data_out and ul_valid=1.
REQ-013 On reaching the final byte, or on busy_flag falling (whichever comes first), the block SHALL go to WAIT_DONE.
REQ-014 WAIT_DONE: when busy_flag=0, SHALL pulse done for one cycle and return to IDLE.
REQ-015 ld_ready and ul_valid SHALL be 0 outside their stream states.
REQ-016 err bits SHALL clear only on reset or on acceptance of a new command.

Reset
REQ-017 While rst=1 at a clock edge: state=IDLE, counter=0, host_instruction=8'h00, data_in=8'h00, ul_data=8'h00, ul_valid=0, ld_ready=0, done=0, err=0, cmd_ready=0. cmd_ready SHALL be 1 in the first cycle after reset.
REQ-018 Reset mid-transfer SHALL abort with no done pulse. The MAU is reset separately by the system.

Configuration
REQ-019 Macro MAU_HOST_TIMEOUT_EN: when defined, a 10-bit watchdog SHALL count cycles spent in STREAM_LD, STREAM_UL and WAIT_DONE. At 1023 it SHALL set err[1], pulse done and go to IDLE.
REQ-020 When MAU_HOST_TIMEOUT_EN is undefined, no watchdog logic SHALL exist, and WAIT_DONE SHALL wait indefinitely for busy_flag=0.

Verification
REQ-021 LOAD to BRAM 2: cmd 8'b10_00_01_00, ld_valid=1 with ld_data 1..64 -> 64 ld_ready cycles, data_in sequence 1..64, one done pulse, err=0.
REQ-022 UNLOAD from BRAM 1: cmd 8'b01_00_01_10, MAU model returns bytes 1..64 -> 64 ul_valid cycles carrying 1..64, then done.
REQ-023 Underrun: LOAD with ld_valid=0 for bytes 10..12 -> err[0]=1, data_in holds byte 9 during the gap, still exactly 64 cycles, done.
REQ-024 ADD: cmd 8'b00_01_11_00, busy high 5 cycles -> host_instruction non-zero for exactly one cycle, no ld_ready or ul_valid, done after busy falls.
REQ-025 Busy timeout: CLEAR issued, model never raises busy -> err[1]=1 and done at cycle BUSY_WAIT after issue.
REQ-026 Reset after byte 30 of a LOAD -> all outputs at their REQ-017 reset values, no done, cmd_ready=1 in the next cycle.
